// File: rtl/alu_checker.sv
// Two-stage ALU result checker: recomputes the expected result and flags for each
// observed transaction, counts checks/mismatches and captures the first failure.
module alu_checker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [31:0]      in_result,
  input  logic [2:0]       in_flags,
  input  logic             clr,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sticky,
  output logic             fail_valid,
  output logic [1:0]       cap_op,
  output logic [31:0]      cap_a,
  output logic [31:0]      cap_b,
  output logic [31:0]      cap_result,
  output logic [2:0]       cap_flags,
  output logic [31:0]      cap_exp_result,
  output logic [2:0]       cap_exp_flags
);

  typedef enum logic {EMPTY, CAPTURED} cap_state_t;

  // Returns {overflow, carry, zero, result}.
  function automatic logic [34:0] exp_calc(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        cy;
    logic        ov;
    s  = 33'd0;
    r  = 32'd0;
    cy = 1'b0;
    ov = 1'b0;
    case (op)
      2'b00: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        cy = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      2'b01: begin
        s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r  = s[31:0];
        cy = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {ov, cy, (r == 32'h0), r};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic             vld_p0;
  logic [1:0]       op_p0;
  logic [31:0]      a_p0;
  logic [31:0]      b_p0;
  logic [31:0]      res_p0;
  logic [2:0]       flags_p0;
  logic [34:0]      exp_p0;

  logic             vld_p1;
  logic             mis_p1;
  logic [1:0]       op_p1;
  logic [31:0]      a_p1;
  logic [31:0]      b_p1;
  logic [31:0]      res_p1;
  logic [2:0]       flags_p1;
  logic [31:0]      exp_res_p1;
  logic [2:0]       exp_flags_p1;

  cap_state_t       state;
  cap_state_t       state_nx;
  logic             load_cap;

  // Stage 1: register the observed transaction
  always_ff @(posedge clk) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= in_valid & ~clr;
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      op_p0    <= in_op;
      a_p0     <= in_a;
      b_p0     <= in_b;
      res_p0   <= in_result;
      flags_p0 <= in_flags;
    end
  end

  assign exp_p0 = exp_calc(op_p0, a_p0, b_p0);

  // Stage 2: expected values and compare result
  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0 & ~clr;
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      op_p1        <= op_p0;
      a_p1         <= a_p0;
      b_p1         <= b_p0;
      res_p1       <= res_p0;
      flags_p1     <= flags_p0;
      exp_res_p1   <= exp_p0[31:0];
      exp_flags_p1 <= exp_p0[34:32];
      mis_p1       <= {flags_p0, res_p0} != exp_p0;
    end
  end

  // Output update: counters, sticky error and fail pulse
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      chk_count  <= '0;
      err_count  <= '0;
      err_sticky <= 1'b0;
      fail_valid <= 1'b0;
    end else begin
      fail_valid <= vld_p1 & mis_p1;
      if (vld_p1) chk_count <= sat_inc(chk_count);
      if (vld_p1 && mis_p1) begin
        err_count  <= sat_inc(err_count);
        err_sticky <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_cap = 1'b0;
    if (clr) begin
      state_nx = EMPTY;
    end else if (state == EMPTY && vld_p1 && mis_p1) begin
      state_nx = CAPTURED;
      load_cap = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cap_op         <= '0;
      cap_a          <= '0;
      cap_b          <= '0;
      cap_result     <= '0;
      cap_flags      <= '0;
      cap_exp_result <= '0;
      cap_exp_flags  <= '0;
    end else if (load_cap) begin
      cap_op         <= op_p1;
      cap_a          <= a_p1;
      cap_b          <= b_p1;
      cap_result     <= res_p1;
      cap_flags      <= flags_p1;
      cap_exp_result <= exp_res_p1;
      cap_exp_flags  <= exp_flags_p1;
    end
  end

endmodule

// File: tb/tb_alu_checker.sv
// Scoreboard bench for alu_checker: directed vectors with hand-computed verdicts,
// plus directed checks for clr/reset interaction and counter saturation.
module tb_alu_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_a = 32'h0;
  logic [31:0] in_b = 32'h0;
  logic [31:0] in_result = 32'h0;
  logic [2:0]  in_flags = 3'b000;
  logic        clr = 1'b0;

  logic [15:0] chk_count, err_count;
  logic        err_sticky, fail_valid;
  logic [1:0]  cap_op;
  logic [31:0] cap_a, cap_b, cap_result, cap_exp_result;
  logic [2:0]  cap_flags, cap_exp_flags;

  logic [3:0]  s_chk_count, s_err_count;
  logic        s_err_sticky, s_fail_valid;
  logic [1:0]  s_cap_op;
  logic [31:0] s_cap_a, s_cap_b, s_cap_result, s_cap_exp_result;
  logic [2:0]  s_cap_flags, s_cap_exp_flags;

  alu_checker #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_a(in_a),
    .in_b(in_b), .in_result(in_result), .in_flags(in_flags), .clr(clr),
    .chk_count(chk_count), .err_count(err_count), .err_sticky(err_sticky),
    .fail_valid(fail_valid), .cap_op(cap_op), .cap_a(cap_a), .cap_b(cap_b),
    .cap_result(cap_result), .cap_flags(cap_flags),
    .cap_exp_result(cap_exp_result), .cap_exp_flags(cap_exp_flags)
  );

  alu_checker #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_a(in_a),
    .in_b(in_b), .in_result(in_result), .in_flags(in_flags), .clr(clr),
    .chk_count(s_chk_count), .err_count(s_err_count), .err_sticky(s_err_sticky),
    .fail_valid(s_fail_valid), .cap_op(s_cap_op), .cap_a(s_cap_a), .cap_b(s_cap_b),
    .cap_result(s_cap_result), .cap_flags(s_cap_flags),
    .cap_exp_result(s_cap_exp_result), .cap_exp_flags(s_cap_exp_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        fv;
    logic [15:0] chk;
    logic [15:0] err;
    logic        st;
  } exp_t;

  exp_t sbq[$];
  int n_pass = 0;
  int n_tot  = 0;
  logic [15:0] m_chk = 0;
  logic [15:0] m_err = 0;
  logic        m_st  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compare DUT outputs in the cycle each transaction is due
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      exp_t e;
      e = sbq.pop_front();
      check("sb_chk_count", 32'(chk_count), 32'(e.chk));
      check("sb_err_count", 32'(err_count), 32'(e.err));
      check("sb_fail_valid", 32'(fail_valid), 32'(e.fv));
      check("sb_err_sticky", 32'(err_sticky), 32'(e.st));
    end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
      check("sb_late", cyc, sbq[0].due);
      void'(sbq.pop_front());
    end
  end

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [2:0] f);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_result = r; in_flags = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [2:0] f, input logic bad);
    exp_t e;
    m_chk++;
    if (bad) m_err++;
    m_st |= bad;
    e.due = cyc + 3; e.fv = bad; e.chk = m_chk; e.err = m_err; e.st = m_st;
    sbq.push_back(e);
    drive(op, a, b, r, f);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sbq.size() > 0; i++) @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      check("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic do_clr();
    clr = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    m_chk = 0; m_err = 0; m_st = 0;
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    check("rst_chk_count", 32'(chk_count), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_err_sticky", 32'(err_sticky), 0);
    check("rst_fail_valid", 32'(fail_valid), 0);
    check("rst_cap_result", cap_result, 0);
    check("rst_cap_exp_flags", 32'(cap_exp_flags), 0);

    // Basic good transactions
    issue(2'b00, 32'd2, 32'd3, 32'd5, 3'b000, 1'b0);
    drain();
    do_clr();
    issue(2'b01, 32'd1, 32'd3, 32'hFFFF_FFFE, 3'b000, 1'b0);
    issue(2'b10, 32'd1, 32'd1, 32'd1, 3'b000, 1'b0);
    drain();
    check("and_sub_chk_count", 32'(chk_count), 2);

    // Flag corner cases, all consistent
    issue(2'b01, 32'd5, 32'd5, 32'd0, 3'b011, 1'b0);
    issue(2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0, 3'b011, 1'b0);
    issue(2'b01, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 3'b110, 1'b0);
    issue(2'b11, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 3'b000, 1'b0);
    issue(2'b10, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0, 3'b001, 1'b0);
    drain();

    // Missing overflow flag
    do_clr();
    issue(2'b00, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 3'b000, 1'b1);
    drain();
    check("ovf_cap_exp_flags", 32'(cap_exp_flags), 32'h4);
    check("ovf_cap_exp_result", cap_exp_result, 32'h8000_0000);
    check("ovf_cap_a", cap_a, 32'h7FFF_FFFF);
    check("ovf_cap_op", 32'(cap_op), 0);

    // Back-to-back mismatches; capture keeps the first
    do_clr();
    issue(2'b00, 32'd2, 32'd3, 32'd6, 3'b000, 1'b1);
    issue(2'b11, 32'd0, 32'd0, 32'd0, 3'b000, 1'b1);
    drain();
    check("b2b_cap_result", cap_result, 32'd6);
    check("b2b_cap_exp_result", cap_exp_result, 32'd5);
    check("b2b_cap_exp_flags", 32'(cap_exp_flags), 0);
    check("b2b_cap_op", 32'(cap_op), 0);

    // clr coincides with a mismatch reaching the output stage
    do_clr();
    drive(2'b00, 32'd2, 32'd3, 32'd5, 3'b000);
    drive(2'b00, 32'd2, 32'd3, 32'd9, 3'b000);
    idle(1);
    check("pre_clr_chk_count", 32'(chk_count), 1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_fail_valid", 32'(fail_valid), 0);
    check("clr_chk_count", 32'(chk_count), 0);
    check("clr_err_count", 32'(err_count), 0);
    check("clr_err_sticky", 32'(err_sticky), 0);
    check("clr_cap_result", cap_result, 0);
    idle(3);
    check("clr_after_err_count", 32'(err_count), 0);
    check("clr_after_fail_valid", 32'(fail_valid), 0);

    // Reset mid-stream
    drive(2'b00, 32'd2, 32'd3, 32'd5, 3'b000);
    drive(2'b00, 32'd2, 32'd3, 32'd7, 3'b000);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(4);
    check("rstmid_chk_count", 32'(chk_count), 0);
    check("rstmid_err_count", 32'(err_count), 0);
    check("rstmid_err_sticky", 32'(err_sticky), 0);
    check("rstmid_cap_result", cap_result, 0);

    // in_valid together with clr is dropped
    clr = 1'b1;
    drive(2'b00, 32'd1, 32'd1, 32'd5, 3'b000);
    clr = 1'b0;
    idle(4);
    check("clr_in_valid_chk_count", 32'(chk_count), 0);
    check("clr_in_valid_err_count", 32'(err_count), 0);

    // 4-bit counters saturate
    do_clr();
    for (int i = 1; i <= 20; i++)
      issue(2'b00, 32'(i), 32'(i), 32'(2 * i), 3'b000, 1'b0);
    drain();
    check("sat_small_chk_count", 32'(s_chk_count), 32'hF);
    idle(2);
    check("sat_small_chk_hold", 32'(s_chk_count), 32'hF);
    check("sat_small_err_count", 32'(s_err_count), 0);
    check("sat_main_chk_count", 32'(chk_count), 20);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
